commit_trap_ctrl: RTL and testbench

//  Consumer side of the ROB commit interface. Watches each committed ROB line (valid, exp, mret,
//  wfi, ecause, pc) and takes machine-mode traps, mret returns and WFI sleeps. Drives the trapped

---
 rtl/commit_trap_ctrl_pkg.sv | 36 +++
 rtl/commit_trap_ctrl_irq_prio_enc.sv | 30 +++
 rtl/commit_trap_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_commit_trap_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_trap_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// commit_trap_ctrl_pkg
// Shared definitions for the commit-side trap controller: FSM state encoding,
// machine interrupt cause codes, the mcause interrupt-bit index, pending-line
// bit positions and a helper that builds an mcause word.
// -----------------------------------------------------------------------------
package commit_trap_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_WFI   = 2'd2
    } state_e;

    // Machine interrupt cause codes.
    localparam logic [3:0] IRQ_MEI = 4'd11;
    localparam logic [3:0] IRQ_MSI = 4'd3;
    localparam logic [3:0] IRQ_MTI = 4'd7;

    localparam int MCAUSE_INT_BIT = 31;

    // Bit positions inside the {eip,tip,sip} pending/enable vectors.
    localparam int IRQ_SIP_BIT = 0;
    localparam int IRQ_TIP_BIT = 1;
    localparam int IRQ_EIP_BIT = 2;

    // {interrupt, 27'b0, code[3:0]}
    function automatic logic [31:0] make_mcause(input logic is_int, input logic [3:0] code);
        logic [31:0] v;
        v                 = 32'd0;
        v[MCAUSE_INT_BIT] = is_int;
        v[3:0]            = code;
        return v;
    endfunction

endpackage

// File: rtl/commit_trap_ctrl_irq_prio_enc.sv
// -----------------------------------------------------------------------------
// commit_trap_ctrl_irq_prio_enc
// Combinational priority encoder for the active (pending & enabled) machine
// interrupts. Priority: external (11) > software (3) > timer (7).
// Ports:
//   i_irq_act  in  3  {eip,tip,sip} already masked by the enables
//   o_any      out 1  at least one interrupt is active
//   o_code     out 4  cause code of the winning interrupt (don't care if !o_any)
// -----------------------------------------------------------------------------
module commit_trap_ctrl_irq_prio_enc
    import commit_trap_ctrl_pkg::*;
(
    input  logic [2:0] i_irq_act,
    output logic       o_any,
    output logic [3:0] o_code
);

    assign o_any = |i_irq_act;

    // Timer is the fall-through: it is only reported when neither eip nor sip is set.
    always_comb begin
        o_code = IRQ_MTI;
        if (i_irq_act[IRQ_EIP_BIT]) begin
            o_code = IRQ_MEI;
        end else if (i_irq_act[IRQ_SIP_BIT]) begin
            o_code = IRQ_MSI;
        end
    end

endmodule

// File: rtl/commit_trap_ctrl.sv
// -----------------------------------------------------------------------------
// commit_trap_ctrl
// Consumer side of the ROB commit interface. Takes machine-mode exceptions,
// interrupts, mret returns and WFI sleeps; drives the flush (trapped) and
// sleep stall (wfi_ctrl) back to rename/commit and redirects fetch.
// Owns mepc, mcause, mstatus.MIE and mstatus.MPIE. All outputs are registered.
// Ports:
//   clk, reset              clock; asynchronous active-low reset
//   rob_commit_valid        a ROB line commits this cycle
//   rob_cm_exp/mret/wfi     kind of the committing line
//   rob_cm_ecause [3:0]     exception cause
//   rob_cm_exp_pc           pc of the committing line
//   rob_cm_next_pc          architectural next pc of the committing line
//   mtvec_in                trap vector base (direct mode, bits [1:0] ignored)
//   irq_pending/irq_enable  {eip,tip,sip} / {meie,mtie,msie}
//   trapped                 flush request, held FLUSH_CYCLES cycles
//   wfi_ctrl                stall while sleeping in WFI
//   redirect_valid/_pc      one-cycle fetch restart pulse and address
//   mepc_out, mcause_out    CSR values
//   mstatus_mie_out         mstatus.MIE
// -----------------------------------------------------------------------------
module commit_trap_ctrl
    import commit_trap_ctrl_pkg::*;
#(
    parameter int PC_WIDTH        = 32,
    parameter int FLUSH_CYCLES    = 2,
    parameter int FLUSH_CNT_WIDTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rob_commit_valid,
    input  logic                rob_cm_exp,
    input  logic                rob_cm_mret,
    input  logic                rob_cm_wfi,
    input  logic [3:0]          rob_cm_ecause,
    input  logic [PC_WIDTH-1:0] rob_cm_exp_pc,
    input  logic [PC_WIDTH-1:0] rob_cm_next_pc,
    input  logic [PC_WIDTH-1:0] mtvec_in,
    input  logic [2:0]          irq_pending,
    input  logic [2:0]          irq_enable,
    output logic                trapped,
    output logic                wfi_ctrl,
    output logic                redirect_valid,
    output logic [PC_WIDTH-1:0] redirect_pc,
    output logic [PC_WIDTH-1:0] mepc_out,
    output logic [31:0]         mcause_out,
    output logic                mstatus_mie_out
);

    localparam logic [FLUSH_CNT_WIDTH-1:0] FLUSH_LAST = FLUSH_CNT_WIDTH'(FLUSH_CYCLES - 1);

    state_e                     r_state,          w_state_nxt;
    logic [FLUSH_CNT_WIDTH-1:0] r_flush_cnt,      w_flush_cnt_nxt;
    logic                       r_trapped,        w_trapped_nxt;
    logic                       r_wfi_ctrl,       w_wfi_ctrl_nxt;
    logic                       r_redirect_valid, w_redirect_valid_nxt;
    logic [PC_WIDTH-1:0]        r_redirect_pc,    w_redirect_pc_nxt;
    logic [PC_WIDTH-1:0]        r_wfi_npc,        w_wfi_npc_nxt;
    logic [PC_WIDTH-1:0]        r_mepc,           w_mepc_nxt;
    logic [31:0]                r_mcause,         w_mcause_nxt;
    logic                       r_mie,            w_mie_nxt;
    logic                       r_mpie,           w_mpie_nxt;

    logic                       w_irq_any;
    logic [3:0]                 w_irq_code;
    logic [PC_WIDTH-1:0]        w_trap_vec;

    // Direct mode: the low two bits of mtvec are mode bits, never part of the vector.
    assign w_trap_vec = mtvec_in & {{(PC_WIDTH-2){1'b1}}, 2'b00};

    commit_trap_ctrl_irq_prio_enc u_irq_prio_enc (
        .i_irq_act (irq_pending & irq_enable),
        .o_any     (w_irq_any),
        .o_code    (w_irq_code)
    );

    always_comb begin
        // NOTE: every next-state signal gets a hold/default value first so no path leaves it unassigned (no latches).
        w_state_nxt          = r_state;
        w_flush_cnt_nxt      = r_flush_cnt;
        w_trapped_nxt        = r_trapped;
        w_wfi_ctrl_nxt       = r_wfi_ctrl;
        w_redirect_valid_nxt = 1'b0;
        w_redirect_pc_nxt    = r_redirect_pc;
        w_wfi_npc_nxt        = r_wfi_npc;
        w_mepc_nxt           = r_mepc;
        w_mcause_nxt         = r_mcause;
        w_mie_nxt            = r_mie;
        w_mpie_nxt           = r_mpie;

        unique case (r_state)
            ST_RUN: begin
                if (rob_commit_valid) begin
                    if (rob_cm_exp) begin
                        w_mepc_nxt           = rob_cm_exp_pc;
                        w_mcause_nxt         = make_mcause(1'b0, rob_cm_ecause);
                        w_mpie_nxt           = r_mie;
                        w_mie_nxt            = 1'b0;
                        w_redirect_pc_nxt    = w_trap_vec;
                        w_redirect_valid_nxt = 1'b1;
                        w_trapped_nxt        = 1'b1;
                        w_flush_cnt_nxt      = '0;
                        w_state_nxt          = ST_FLUSH;
                    end else if (rob_cm_mret) begin
                        w_mie_nxt            = r_mpie;
                        w_mpie_nxt           = 1'b1;
                        w_redirect_pc_nxt    = r_mepc;
                        w_redirect_valid_nxt = 1'b1;
                        w_trapped_nxt        = 1'b1;
                        w_flush_cnt_nxt      = '0;
                        w_state_nxt          = ST_FLUSH;
                    end else if (rob_cm_wfi) begin
                        w_wfi_npc_nxt  = rob_cm_next_pc;
                        w_wfi_ctrl_nxt = 1'b1;
                        w_state_nxt    = ST_WFI;
                    end else if (r_mie && w_irq_any) begin
                        // Interrupt is taken after the committing instruction retires.
                        w_mepc_nxt           = rob_cm_next_pc;
                        w_mcause_nxt         = make_mcause(1'b1, w_irq_code);
                        w_mpie_nxt           = r_mie;
                        w_mie_nxt            = 1'b0;
                        w_redirect_pc_nxt    = w_trap_vec;
                        w_redirect_valid_nxt = 1'b1;
                        w_trapped_nxt        = 1'b1;
                        w_flush_cnt_nxt      = '0;
                        w_state_nxt          = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                // Commits are ignored here, including on the exit edge.
                if (r_flush_cnt == FLUSH_LAST) begin
                    w_trapped_nxt   = 1'b0;
                    w_flush_cnt_nxt = '0;
                    w_state_nxt     = ST_RUN;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt + FLUSH_CNT_WIDTH'(1);
                end
            end
            ST_WFI: begin
                // Wake on any enabled pending line; MIE only decides whether to trap.
                if (w_irq_any) begin
                    w_wfi_ctrl_nxt = 1'b0;
                    if (r_mie) begin
                        w_mepc_nxt           = r_wfi_npc;
                        w_mcause_nxt         = make_mcause(1'b1, w_irq_code);
                        w_mpie_nxt           = r_mie;
                        w_mie_nxt            = 1'b0;
                        w_redirect_pc_nxt    = w_trap_vec;
                        w_redirect_valid_nxt = 1'b1;
                        w_trapped_nxt        = 1'b1;
                        w_flush_cnt_nxt      = '0;
                        w_state_nxt          = ST_FLUSH;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; every register here is control/CSR state and is reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state          <= ST_RUN;
            r_flush_cnt      <= '0;
            r_trapped        <= 1'b0;
            r_wfi_ctrl       <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_wfi_npc        <= '0;
            r_mepc           <= '0;
            r_mcause         <= '0;
            r_mie            <= 1'b0;
            r_mpie           <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_flush_cnt      <= w_flush_cnt_nxt;
            r_trapped        <= w_trapped_nxt;
            r_wfi_ctrl       <= w_wfi_ctrl_nxt;
            r_redirect_valid <= w_redirect_valid_nxt;
            r_redirect_pc    <= w_redirect_pc_nxt;
            r_wfi_npc        <= w_wfi_npc_nxt;
            r_mepc           <= w_mepc_nxt;
            r_mcause         <= w_mcause_nxt;
            r_mie            <= w_mie_nxt;
            r_mpie           <= w_mpie_nxt;
        end
    end

    assign trapped         = r_trapped;
    assign wfi_ctrl        = r_wfi_ctrl;
    assign redirect_valid  = r_redirect_valid;
    assign redirect_pc     = r_redirect_pc;
    assign mepc_out        = r_mepc;
    assign mcause_out      = r_mcause;
    assign mstatus_mie_out = r_mie;

endmodule

// File: tb/tb_commit_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_commit_trap_ctrl
// Directed scenarios followed by randomized commit/interrupt traffic, every
// cycle compared against an architectural reference model (CSR variables plus
// a remaining-flush-cycles count and a sleeping flag).
// -----------------------------------------------------------------------------
module tb_commit_trap_ctrl;

    localparam int PCW = 32;
    localparam int FC  = 2;
    localparam int FCW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           rob_commit_valid, rob_cm_exp, rob_cm_mret, rob_cm_wfi;
    logic [3:0]     rob_cm_ecause;
    logic [PCW-1:0] rob_cm_exp_pc, rob_cm_next_pc, mtvec_in;
    logic [2:0]     irq_pending, irq_enable;
    logic           trapped, wfi_ctrl, redirect_valid, mstatus_mie_out;
    logic [PCW-1:0] redirect_pc, mepc_out;
    logic [31:0]    mcause_out;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    bit          m_mie, m_mpie, m_rv, m_sleep;
    logic [31:0] m_mepc, m_mcause, m_rpc, m_wfi_npc;
    int          m_flush_left;

    commit_trap_ctrl #(
        .PC_WIDTH        (PCW),
        .FLUSH_CYCLES    (FC),
        .FLUSH_CNT_WIDTH (FCW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .rob_commit_valid (rob_commit_valid),
        .rob_cm_exp       (rob_cm_exp),
        .rob_cm_mret      (rob_cm_mret),
        .rob_cm_wfi       (rob_cm_wfi),
        .rob_cm_ecause    (rob_cm_ecause),
        .rob_cm_exp_pc    (rob_cm_exp_pc),
        .rob_cm_next_pc   (rob_cm_next_pc),
        .mtvec_in         (mtvec_in),
        .irq_pending      (irq_pending),
        .irq_enable       (irq_enable),
        .trapped          (trapped),
        .wfi_ctrl         (wfi_ctrl),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .mepc_out         (mepc_out),
        .mcause_out       (mcause_out),
        .mstatus_mie_out  (mstatus_mie_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] irq_code(input logic [2:0] act);
        if (act[2]) return 4'd11;
        if (act[0]) return 4'd3;
        return 4'd7;
    endfunction

    task automatic model_reset();
        m_mie = 0; m_mpie = 0; m_rv = 0; m_sleep = 0;
        m_mepc = 0; m_mcause = 0; m_rpc = 0; m_wfi_npc = 0;
        m_flush_left = 0;
    endtask

    task automatic take_trap(input bit is_int, input logic [3:0] code, input logic [31:0] epc);
        m_mepc       = epc;
        m_mcause     = is_int ? (32'h8000_0000 | 32'(code)) : 32'(code);
        m_mpie       = m_mie;
        m_mie        = 0;
        m_rpc        = mtvec_in & ~32'd3;
        m_rv         = 1;
        m_flush_left = FC;
    endtask

    // What one rising edge does to the architectural state, given current inputs.
    task automatic model_edge();
        logic [2:0] act;
        if (!reset) begin
            model_reset();
            return;
        end
        act  = irq_pending & irq_enable;
        m_rv = 0;
        if (m_flush_left > 0) begin
            m_flush_left--;
        end else if (m_sleep) begin
            if (act != 0) begin
                m_sleep = 0;
                if (m_mie) take_trap(1, irq_code(act), m_wfi_npc);
            end
        end else if (rob_commit_valid) begin
            if (rob_cm_exp) begin
                take_trap(0, rob_cm_ecause, rob_cm_exp_pc);
            end else if (rob_cm_mret) begin
                m_rpc        = m_mepc;
                m_mie        = m_mpie;
                m_mpie       = 1;
                m_rv         = 1;
                m_flush_left = FC;
            end else if (rob_cm_wfi) begin
                m_sleep   = 1;
                m_wfi_npc = rob_cm_next_pc;
            end else if (m_mie && act != 0) begin
                take_trap(1, irq_code(act), rob_cm_next_pc);
            end
        end
    endtask

    task automatic compare_all(input string pfx);
        check({pfx, "_trapped"},   32'(trapped),         32'(m_flush_left > 0));
        check({pfx, "_wfi_ctrl"},  32'(wfi_ctrl),        32'(m_sleep));
        check({pfx, "_redir_v"},   32'(redirect_valid),  32'(m_rv));
        check({pfx, "_redir_pc"},  redirect_pc,          m_rpc);
        check({pfx, "_mepc"},      mepc_out,             m_mepc);
        check({pfx, "_mcause"},    mcause_out,           m_mcause);
        check({pfx, "_mie"},       32'(mstatus_mie_out), 32'(m_mie));
    endtask

    // One clock: inputs are already driven; sample #1 after the edge.
    task automatic tick(input string pfx);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(pfx);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick("idle");
    endtask

    task automatic commit(input string pfx, input bit e, input bit mr, input bit w,
                          input logic [3:0] ec, input logic [31:0] pc, input logic [31:0] npc);
        rob_commit_valid = 1; rob_cm_exp = e; rob_cm_mret = mr; rob_cm_wfi = w;
        rob_cm_ecause = ec; rob_cm_exp_pc = pc; rob_cm_next_pc = npc;
        tick(pfx);
        rob_commit_valid = 0; rob_cm_exp = 0; rob_cm_mret = 0; rob_cm_wfi = 0;
    endtask

    // Called #1 after an edge: pull reset low mid-cycle, check immediately, release mid-cycle.
    task automatic async_reset(input string pfx);
        #2;
        reset = 0;
        #1;
        model_reset();
        compare_all(pfx);
        tick(pfx);
        #2;
        reset = 1;
    endtask

    int wfi_cnt;

    initial begin
        reset = 0;
        rob_commit_valid = 0; rob_cm_exp = 0; rob_cm_mret = 0; rob_cm_wfi = 0;
        rob_cm_ecause = 0; rob_cm_exp_pc = 0; rob_cm_next_pc = 0;
        mtvec_in = 32'h8000_0103; irq_pending = 0; irq_enable = 0;
        model_reset();
        #1;
        compare_all("reset");
        idle(2);
        #2 reset = 1;
        idle(2);

        // Two mrets bring MIE up to 1 (first copies MPIE=0 and sets MPIE).
        commit("mret_a", 0, 1, 0, 4'd0, 32'h0, 32'h0); idle(3);
        commit("mret_b", 0, 1, 0, 4'd0, 32'h0, 32'h0); idle(3);
        check("pre_t1_mie", 32'(mstatus_mie_out), 32'd1);

        // Scenario 1: exception with a misaligned mtvec.
        commit("t1", 1, 0, 0, 4'd2, 32'h8000_0010, 32'h8000_0014);
        check("t1_redir_pc_const", redirect_pc, 32'h8000_0100);
        check("t1_mcause_const", mcause_out, 32'h0000_0002);
        tick("t1_f2");
        check("t1_trapped_2nd", 32'(trapped), 32'd1);
        tick("t1_f3");
        check("t1_trapped_off", 32'(trapped), 32'd0);
        idle(1);

        // Scenario 2: mret to 0x80000040 with MPIE=1.
        commit("t2_pre_mret", 0, 1, 0, 4'd0, 32'h0, 32'h0); idle(3);
        commit("t2_pre_exp", 1, 0, 0, 4'd1, 32'h8000_0040, 32'h8000_0044); idle(3);
        commit("t2", 0, 1, 0, 4'd0, 32'h0, 32'h0);
        check("t2_redir_pc_const", redirect_pc, 32'h8000_0040);
        check("t2_mie_const", 32'(mstatus_mie_out), 32'd1);
        idle(3);

        // Scenario 3: interrupt after a commit, eip beats sip.
        irq_enable = 3'b111; irq_pending = 3'b101;
        commit("t3", 0, 0, 0, 4'd0, 32'h100, 32'h200);
        irq_pending = 0;
        check("t3_mcause_const", mcause_out, 32'h8000_000B);
        check("t3_mepc_const", mepc_out, 32'h200);
        idle(3);
        commit("t3_mret", 0, 1, 0, 4'd0, 32'h0, 32'h0); idle(3);

        // Scenario 4: exception wins over same-cycle interrupt.
        irq_pending = 3'b100;
        commit("t4", 1, 0, 0, 4'd5, 32'h0000_1234, 32'h0000_1238);
        irq_pending = 0;
        check("t4_mcause_const", mcause_out, 32'h0000_0005);
        idle(3);
        commit("t4_mret", 0, 1, 0, 4'd0, 32'h0, 32'h0); idle(3);

        // Scenario 5b: WFI with MIE=1, woken by timer.
        commit("t5b_wfi", 0, 0, 1, 4'd0, 32'h2fc, 32'h300);
        idle(9);
        irq_pending = 3'b010;
        tick("t5b_wake");
        irq_pending = 0;
        check("t5b_mcause_const", mcause_out, 32'h8000_0007);
        check("t5b_mepc_const", mepc_out, 32'h300);
        idle(3);

        // Scenario 5a: WFI with MIE=0 (cleared by the trap above).
        wfi_cnt = 0;
        commit("t5a_wfi", 0, 0, 1, 4'd0, 32'h2fc, 32'h300);
        if (wfi_ctrl === 1'b1) wfi_cnt++;
        for (int i = 0; i < 9; i++) begin
            tick("t5a_sleep");
            if (wfi_ctrl === 1'b1) wfi_cnt++;
        end
        irq_pending = 3'b010;
        tick("t5a_wake");
        irq_pending = 0;
        check("t5a_wfi_cycles", 32'(wfi_cnt), 32'd10);
        check("t5a_no_redir", 32'(redirect_valid), 32'd0);
        idle(2);

        // Scenario 6: reset during the first FLUSH cycle.
        commit("t6", 1, 0, 0, 4'd4, 32'h0000_4444, 32'h0000_4448);
        async_reset("t6_rst");
        check("t6_trapped_const", 32'(trapped), 32'd0);
        check("t6_mepc_const", mepc_out, 32'd0);
        commit("t6_run", 1, 0, 0, 4'd6, 32'h0000_5550, 32'h0000_5554);
        idle(3);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            rob_commit_valid = 1'($urandom_range(0, 1));
            rob_cm_exp       = ($urandom_range(0, 7) == 0);
            rob_cm_mret      = ($urandom_range(0, 5) == 0);
            rob_cm_wfi       = ($urandom_range(0, 9) == 0);
            rob_cm_ecause    = 4'($urandom);
            rob_cm_exp_pc    = $urandom;
            rob_cm_next_pc   = $urandom;
            mtvec_in         = $urandom;
            irq_pending      = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
            irq_enable       = 3'($urandom);
            tick("rnd");
            if ($urandom_range(0, 249) == 0) async_reset("rnd_rst");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
